// File: rtl/rob_multi_cdb_pkg.sv
// Shared definitions for the multi-CDB reorder buffer.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
package rob_multi_cdb_pkg;

    localparam int OP_W = 2;

    // Operation class recorded per entry at dispatch.
    typedef enum logic [OP_W-1:0] {
        OP_EMPTY  = 2'd0,
        OP_BRANCH = 2'd1,
        OP_STORE  = 2'd2,
        OP_NORMAL = 2'd3
    } op_t;

    // Whether a ready head of the given class leaves the buffer this cycle.
    // A store also needs the cache to take it; a mispredicted branch never
    // retires normally because it flushes the whole buffer instead.
    function automatic logic head_can_retire(input op_t op, input logic mispredict,
                                             input logic mem_ready);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_EMPTY:  ok = 1'b1;
            OP_BRANCH: ok = !mispredict;
            OP_STORE:  ok = mem_ready;
            OP_NORMAL: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rob_cdb_select.sv
// Tag matcher across NUM_CDB writeback channels; lowest-index match wins.
// Latency: combinational.
// Backpressure: none (pure lookup).
// Ports: tag (entry to match), cdb_* (packed channel buses, channel k at
// [k*W +: W]), hit plus the selected channel's value/addr/mispredict.
module rob_cdb_select #(
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) (
    input  logic [TAG_W-1:0]          tag,
    input  logic [NUM_CDB-1:0]        cdb_write,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_in_entry,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_in_value,
    input  logic [NUM_CDB*ADDR_W-1:0] cdb_in_addr,
    input  logic [NUM_CDB-1:0]        cdb_in_mispredict,
    output logic                      hit,
    output logic [DATA_W-1:0]         sel_value,
    output logic [ADDR_W-1:0]         sel_addr,
    output logic                      sel_mispredict
);

    // Scan from the highest channel down so the lowest matching index is
    // the last assignment and therefore the one that sticks.
    always_comb begin
        hit            = 1'b0;
        sel_value      = '0;
        sel_addr       = '0;
        sel_mispredict = 1'b0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_write[k] && (cdb_in_entry[k*TAG_W +: TAG_W] == tag)) begin
                hit            = 1'b1;
                sel_value      = cdb_in_value[k*DATA_W +: DATA_W];
                sel_addr       = cdb_in_addr[k*ADDR_W +: ADDR_W];
                sel_mispredict = cdb_in_mispredict[k];
            end
        end
    end

endmodule

// File: rtl/rob_multi_cdb.sv
// Parametrised reorder buffer: in-order dispatch, NUM_CDB-way writeback,
// in-order retire to RegFile / store port / fetch redirect.
// Latency: dispatch->ready after 1 edge; retire outputs combinational from head.
// Backpressure: fifo_full drops dispatch; head store stalls until mem_ready.
// Ports: clk/rst (async active-low), dispatch (write, in_op, in_reg, out_lock,
// fifo_full), two operand check ports, packed CDB channels, commit outputs
// (reg_*, mem_*, flush/flush_pc) and mem_ready from the DataCache.
module rob_multi_cdb
    import rob_multi_cdb_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      fifo_full,
    output logic [TAG_W-1:0]          out_lock,
    input  logic                      write,
    input  logic [1:0]                in_op,
    input  logic [REG_W-1:0]          in_reg,
    input  logic                      check1,
    input  logic                      check2,
    input  logic [TAG_W-1:0]          check_entry1,
    input  logic [TAG_W-1:0]          check_entry2,
    output logic [DATA_W-1:0]         check_value1,
    output logic [DATA_W-1:0]         check_value2,
    output logic                      check_value_enable1,
    output logic                      check_value_enable2,
    input  logic [NUM_CDB-1:0]        cdb_write,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_in_entry,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_in_value,
    input  logic [NUM_CDB*ADDR_W-1:0] cdb_in_addr,
    input  logic [NUM_CDB-1:0]        cdb_in_mispredict,
    output logic                      reg_modify,
    output logic [REG_W-1:0]          reg_name,
    output logic [DATA_W-1:0]         reg_data,
    output logic [TAG_W-1:0]          reg_entry,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data,
    input  logic                      mem_ready,
    output logic                      flush,
    output logic [DATA_W-1:0]         flush_pc
);

    typedef struct packed {
        logic               busy;
        logic               ready;
        op_t                op;
        logic [REG_W-1:0]   rname;
        logic [DATA_W-1:0]  value;
        logic [ADDR_W-1:0]  addr;
        logic               mispredict;
    } entry_t;

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    entry_t           rob [DEPTH];
    logic [TAG_W-1:0] read_ptr;
    logic [TAG_W-1:0] write_ptr;
    logic [TAG_W:0]   count;

    entry_t head;
    logic   head_vld;
    logic   retire;
    logic   dispatch;

    // ---------------- CDB write path: one matcher per entry ----------------
    logic              wr_hit   [DEPTH];
    logic [DATA_W-1:0] wr_value [DEPTH];
    logic [ADDR_W-1:0] wr_addr  [DEPTH];
    logic              wr_misp  [DEPTH];

    for (genvar e = 0; e < DEPTH; e++) begin : g_wsel
        rob_cdb_select #(
            .NUM_CDB (NUM_CDB),
            .TAG_W   (TAG_W),
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W)
        ) u_wsel (
            .tag               (TAG_W'(e)),
            .cdb_write         (cdb_write),
            .cdb_in_entry      (cdb_in_entry),
            .cdb_in_value      (cdb_in_value),
            .cdb_in_addr       (cdb_in_addr),
            .cdb_in_mispredict (cdb_in_mispredict),
            .hit               (wr_hit[e]),
            .sel_value         (wr_value[e]),
            .sel_addr          (wr_addr[e]),
            .sel_mispredict    (wr_misp[e])
        );
    end

    // ---------------- Check-port bypass matchers ----------------
    logic              c1_hit, c2_hit;
    logic [DATA_W-1:0] c1_value, c2_value;
    logic [ADDR_W-1:0] unused_c1_addr, unused_c2_addr;
    logic              unused_c1_misp, unused_c2_misp;

    rob_cdb_select #(
        .NUM_CDB (NUM_CDB),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_csel1 (
        .tag               (check_entry1),
        .cdb_write         (cdb_write),
        .cdb_in_entry      (cdb_in_entry),
        .cdb_in_value      (cdb_in_value),
        .cdb_in_addr       (cdb_in_addr),
        .cdb_in_mispredict (cdb_in_mispredict),
        .hit               (c1_hit),
        .sel_value         (c1_value),
        .sel_addr          (unused_c1_addr),
        .sel_mispredict    (unused_c1_misp)
    );

    rob_cdb_select #(
        .NUM_CDB (NUM_CDB),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_csel2 (
        .tag               (check_entry2),
        .cdb_write         (cdb_write),
        .cdb_in_entry      (cdb_in_entry),
        .cdb_in_value      (cdb_in_value),
        .cdb_in_addr       (cdb_in_addr),
        .cdb_in_mispredict (cdb_in_mispredict),
        .hit               (c2_hit),
        .sel_value         (c2_value),
        .sel_addr          (unused_c2_addr),
        .sel_mispredict    (unused_c2_misp)
    );

    // A same-cycle CDB value only counts for an entry still waiting on it;
    // otherwise the stored value and ready bit are authoritative.
    always_comb begin
        check_value1        = '0;
        check_value_enable1 = 1'b0;
        if (check1) begin
            if (c1_hit && rob[check_entry1].busy && !rob[check_entry1].ready) begin
                check_value1        = c1_value;
                check_value_enable1 = 1'b1;
            end else begin
                check_value1        = rob[check_entry1].value;
                check_value_enable1 = rob[check_entry1].ready;
            end
        end
    end

    always_comb begin
        check_value2        = '0;
        check_value_enable2 = 1'b0;
        if (check2) begin
            if (c2_hit && rob[check_entry2].busy && !rob[check_entry2].ready) begin
                check_value2        = c2_value;
                check_value_enable2 = 1'b1;
            end else begin
                check_value2        = rob[check_entry2].value;
                check_value_enable2 = rob[check_entry2].ready;
            end
        end
    end

    // ---------------- Head / commit decode ----------------
    assign head      = rob[read_ptr];
    assign head_vld  = (count != '0) && head.busy && head.ready;
    assign fifo_full = (count == FULL_CNT);
    assign out_lock  = write_ptr;

    assign flush      = head_vld && (head.op == OP_BRANCH) && head.mispredict;
    assign mem_write  = head_vld && (head.op == OP_STORE);
    assign reg_modify = head_vld && (head.op == OP_NORMAL);
    assign retire     = head_vld && head_can_retire(head.op, head.mispredict, mem_ready);
    assign dispatch   = write && !fifo_full && !flush;

    // Data outputs are gated by their strobes so idle buses read as zero.
    assign flush_pc  = flush      ? head.value : '0;
    assign mem_addr  = mem_write  ? head.addr  : '0;
    assign mem_data  = mem_write  ? head.value : '0;
    assign reg_name  = reg_modify ? head.rname : '0;
    assign reg_data  = reg_modify ? head.value : '0;
    assign reg_entry = reg_modify ? read_ptr   : '0;

    // ---------------- State update ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_ptr  <= '0;
            write_ptr <= '0;
            count     <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rob[e] <= '0;
            end
        end else if (flush) begin
            // Everything younger than the mispredicted branch is wrong-path.
            read_ptr  <= '0;
            write_ptr <= '0;
            count     <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rob[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_hit[e] && rob[e].busy && !rob[e].ready) begin
                    rob[e].ready      <= 1'b1;
                    rob[e].value      <= wr_value[e];
                    rob[e].addr       <= wr_addr[e];
                    rob[e].mispredict <= wr_misp[e];
                end
            end
            // The retiring head is already ready (no CDB update) and the
            // dispatch slot is free, so these never collide with the above.
            if (retire) begin
                rob[read_ptr].busy  <= 1'b0;
                rob[read_ptr].ready <= 1'b0;
                read_ptr            <= read_ptr + TAG_W'(1);
            end
            if (dispatch) begin
                rob[write_ptr].busy       <= 1'b1;
                rob[write_ptr].ready      <= (op_t'(in_op) == OP_EMPTY);
                rob[write_ptr].op         <= op_t'(in_op);
                rob[write_ptr].rname      <= in_reg;
                rob[write_ptr].mispredict <= 1'b0;
                write_ptr                 <= write_ptr + TAG_W'(1);
            end
            count <= count + {{TAG_W{1'b0}}, dispatch} - {{TAG_W{1'b0}}, retire};
        end
    end

endmodule
